// File: rtl/axis_pixels_fifo_pkg.sv
// Shared pixel-stream parameters: beat geometry, per-beat user struct and FIFO occupancy states.
// ROWS and WORD_WIDTH may be overridden with the `ROWS / `WORD_WIDTH macros.
`ifndef ROWS
`define ROWS 4
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif

package axis_pixels_fifo_pkg;

  localparam int ROWS_C       = `ROWS;
  localparam int WORD_WIDTH_C = `WORD_WIDTH;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic [1:0] tag;
  } tuser_st;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_e;

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_ram_sdp #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_pixels_fifo.sv
// Pixel-column AXIS FIFO between the shift stage and the engine.
// Define AXIS_PIXELS_FIFO_OREG_EN to drive m_* from an output register (counted in DEPTH).
`ifndef ROWS
`define ROWS 4
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif

module axis_pixels_fifo
  import axis_pixels_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ROWS       = `ROWS,
  parameter int WORD_WIDTH = `WORD_WIDTH
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  output logic                         s_ready,
  input  logic                         s_valid,
  input  logic [ROWS*WORD_WIDTH-1:0]   s_data,
  input  tuser_st                      s_user,
  input  logic                         m_ready,
  output logic                         m_valid,
  output logic [ROWS*WORD_WIDTH-1:0]   m_data,
  output tuser_st                      m_user,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = ROWS * WORD_WIDTH;
  localparam int UW = $bits(tuser_st);
  localparam int MW = DW + UW;

  logic          wr_fire, rd_fire, ram_rd_en;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          s_ready_q, s_ready_d;
  logic          m_valid_q, m_valid_d;
  occ_state_e    state_q, state_d;
  logic [MW-1:0] ram_wr_data, ram_rd_data;

  assign wr_fire     = s_valid & s_ready_q;
  assign rd_fire     = m_valid_q & m_ready;
  assign ram_wr_data = {s_data, s_user};

  fifo_ram_sdp #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr_q),
    .wr_data (ram_wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    wr_ptr_d  = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = ram_rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + {{AW{1'b0}}, wr_fire} - {{AW{1'b0}}, rd_fire};
    s_ready_d = (count_d < CW'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (wr_fire) state_d = PARTIAL;
      PARTIAL: begin
        if (wr_fire && !rd_fire && count_q == CW'(DEPTH - 1)) state_d = FULL;
        else if (rd_fire && !wr_fire && count_q == CW'(1))    state_d = EMPTY;
      end
      FULL:    if (rd_fire) state_d = PARTIAL;
      default: state_d = EMPTY;
    endcase
  end

`ifdef AXIS_PIXELS_FIFO_OREG_EN
  logic [CW-1:0] ram_count;
  logic [MW-1:0] oreg_q, oreg_d;

  // Refill the output register whenever it is empty or being drained this cycle.
  always_comb begin
    ram_count = count_q - {{AW{1'b0}}, m_valid_q};
    ram_rd_en = (ram_count != '0) && (!m_valid_q || m_ready);
    m_valid_d = ram_rd_en || (m_valid_q && !m_ready);
    oreg_d    = ram_rd_en ? ram_rd_data : oreg_q;
  end

  always_ff @(posedge aclk) begin
    oreg_q <= oreg_d;
  end

  assign {m_data, m_user} = oreg_q;
`else
  always_comb begin
    ram_rd_en = rd_fire;
    m_valid_d = (state_d != EMPTY);
  end

  assign {m_data, m_user} = ram_rd_data;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      state_q   <= EMPTY;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      state_q   <= state_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign count   = count_q;

endmodule

// File: tb/tb_axis_pixels_fifo.sv
// Randomized + directed bench for axis_pixels_fifo against a queue-based reference model.
module tb_axis_pixels_fifo;
  import axis_pixels_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = ROWS_C * WORD_WIDTH_C;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef AXIS_PIXELS_FIFO_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  tuser_st       s_user = '0;
  logic          s_ready, m_valid;
  logic [DW-1:0] m_data;
  tuser_st       m_user;
  logic [CW-1:0] count;
  logic [3:0]    mu;

  assign mu = m_user;

  always #5 aclk = ~aclk;

  axis_pixels_fifo #(.DEPTH(DEPTH)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_ready (s_ready),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_user  (s_user),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_user  (m_user),
    .count   (count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: accepted beats in order, tagged with the edge they were accepted on.
  logic [DW-1:0] q_d[$];
  logic [3:0]    q_u[$];
  int            q_e[$];
  int            edges = 0;
  logic          exp_sr = 1'b0;

  logic [DW-1:0] nxt_data = '0;
  logic [3:0]    nxt_user = '0;
  bit            seq_mode = 1'b0;
  int            seq_idx = 0;
  int            dut_in = 0, dut_out = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic [3:0]    stall_user = '0;
  bit            stream_mon = 1'b0, seen_mv = 1'b0;
  int            bubbles = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic regen();
    if (seq_mode) begin
      nxt_data = DW'(seq_idx);
      nxt_user = 4'(seq_idx);
    end else begin
      nxt_data = DW'($urandom);
      nxt_user = 4'($urandom);
    end
  endtask

  task automatic cyc(input logic sv, input logic mr);
    logic exp_mv, wr, rd;
    s_valid = sv;
    m_ready = mr;
    s_data  = nxt_data;
    s_user  = nxt_user;
    @(negedge aclk);
    exp_mv = (q_d.size() > 0) && ((edges - q_e[0]) >= LAT - 1);
    chk("s_ready", {63'd0, s_ready}, {63'd0, exp_sr});
    chk("m_valid", {63'd0, m_valid}, {63'd0, exp_mv});
    chk("count", 64'(count), 64'(q_d.size()));
    if (exp_mv) begin
      chk("m_data", 64'(m_data), 64'(q_d[0]));
      chk("m_user", 64'(mu), 64'(q_u[0]));
    end
    if (stall_prev) begin
      chk("hold_valid", {63'd0, m_valid}, 64'd1);
      chk("hold_data", 64'(m_data), 64'(stall_data));
      chk("hold_user", 64'(mu), 64'(stall_user));
    end
    stall_prev = m_valid && !m_ready && aresetn;
    stall_data = m_data;
    stall_user = mu;
    if (stream_mon) begin
      if (seen_mv && !m_valid) bubbles++;
      if (m_valid) seen_mv = 1'b1;
    end
    if (aresetn && s_valid && s_ready) dut_in++;
    if (aresetn && m_valid && m_ready) dut_out++;
    wr = aresetn && sv && exp_sr;
    rd = aresetn && mr && exp_mv;
    @(posedge aclk);
    edges++;
    if (!aresetn) begin
      q_d.delete(); q_u.delete(); q_e.delete();
      exp_sr = 1'b0;
    end else begin
      if (rd) begin
        void'(q_d.pop_front()); void'(q_u.pop_front()); void'(q_e.pop_front());
      end
      if (wr) begin
        q_d.push_back(nxt_data); q_u.push_back(nxt_user); q_e.push_back(edges);
        if (seq_mode) seq_idx++;
        regen();
      end
      exp_sr = (q_d.size() < DEPTH);
    end
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    cyc(0, 0);
    aresetn = 1'b1;
    cyc(0, 0);
    dut_in  = 0;
    dut_out = 0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && q_d.size() > 0; i++) cyc(0, 1);
    chk(tag, 64'(count), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] first;
    int p_in, p_out;
    @(posedge aclk);
    #1;
    regen();
    cyc(0, 0);
    aresetn = 1'b1;
    cyc(0, 0);

    // Fill / drain with indexed data
    do_reset();
    seq_mode = 1'b1; seq_idx = 0; regen();
    for (int i = 0; i < 20; i++) cyc(1, 0);
    chk("fd_count", 64'(count), 64'd16);
    chk("fd_sready", {63'd0, s_ready}, 64'd0);
    for (int i = 0; i < 100 && seq_idx < 20; i++) cyc(1, 1);
    drain("fd_empty");
    chk("fd_out", 64'(dut_out), 64'd20);
    seq_mode = 1'b0; regen();

    // Streaming
    do_reset();
    stream_mon = 1'b1; seen_mv = 1'b0; bubbles = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1, 1);
      if (i == 50) chk("stream_count", 64'(count), 64'(LAT));
    end
    stream_mon = 1'b0;
    drain("stream_empty");
    chk("stream_out", 64'(dut_out), 64'd100);
    chk("stream_bubbles", 64'(bubbles), 64'd0);

    // Backpressure
    do_reset();
    for (int i = 0; i < 400; i++) cyc($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1);
    drain("bp_empty");
    chk("bp_loss", 64'(dut_out), 64'(dut_in));

    // Full plus simultaneous
    do_reset();
    for (int i = 0; i < 40 && q_d.size() < DEPTH; i++) cyc(1, 0);
    chk("fs_full", 64'(count), 64'd16);
    cyc(1, 1);
    chk("fs_count", 64'(count), 64'd15);
    chk("fs_sready", {63'd0, s_ready}, 64'd1);
    cyc(1, 0);
    chk("fs_refill", 64'(count), 64'd16);
    drain("fs_empty");

    // Wrap with varied occupancy
    do_reset();
    p_in = 50; p_out = 50;
    for (int i = 0; i < 2000 && dut_out < 3 * DEPTH + 5; i++) begin
      if (i % 16 == 0) begin
        p_in  = $urandom_range(20, 95);
        p_out = $urandom_range(20, 95);
      end
      cyc($urandom_range(0, 99) < p_in, $urandom_range(0, 99) < p_out);
    end
    chk("wrap_out", {63'd0, dut_out >= 3 * DEPTH + 5}, 64'd1);
    drain("wrap_empty");

    // Reset mid-stream
    do_reset();
    for (int i = 0; i < 40 && q_d.size() < 9; i++) cyc(1, 0);
    chk("rst_pre", 64'(count), 64'd9);
    aresetn = 1'b0;
    cyc(1, 1);
    aresetn = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_mvalid", {63'd0, m_valid}, 64'd0);
    first = nxt_data;
    for (int i = 0; i < 4; i++) cyc(1, 0);
    chk("rst_first_valid", {63'd0, m_valid}, 64'd1);
    chk("rst_first", 64'(m_data), 64'(first));
    drain("rst_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_pixels_fifo.md
AXIS_PIXELS_FIFO -- requirements
Module: axis_pixels_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning the number of beat entries; it SHALL be a power of two and at least 4.
REQ-002 Parameter ROWS, default `ROWS, meaning the number of words per beat.
REQ-003 Parameter WORD_WIDTH, default `WORD_WIDTH, meaning the bits per word.
REQ-004 Port aclk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-006 Port s_ready, output, 1 bit: the FIFO can accept a beat.
REQ-007 Port s_valid, input, 1 bit: a beat is offered from the pixels shift stage.
REQ-008 Port s_data, input, ROWS x WORD_WIDTH: the pixel column.
REQ-009 Port s_user, input, tuser_st: per-beat control, carried unmodified.
REQ-010 Port m_ready, input, 1 bit: the engine accepts a beat.
REQ-011 Port m_valid, output, 1 bit: a beat is available.
REQ-012 Port m_data, output, ROWS x WORD_WIDTH: the pixel column.
REQ-013 Port m_user, output, tuser_st: the control bits paired with m_data.
REQ-014 Port count, output, $clog2(DEPTH)+1 bits: the number of beats held, including any output-register beat.

Function
REQ-015 A beat SHALL be written when s_valid and s_ready are both high; a beat SHALL be read when m_valid and m_ready are both high.
REQ-016 s_ready SHALL be registered, and SHALL be high iff count < DEPTH, evaluated after the previous edge.
REQ-017 s_ready SHALL NOT depend combinationally on m_ready or s_valid.
REQ-018 Order SHALL be strict FIFO; s_data and s_user SHALL stay paired bit-exact.
REQ-019 Read and write pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap modulo DEPTH with no special case.
REQ-020 On a simultaneous write and read, count SHALL be unchanged; this SHALL hold when full and when holding exactly one beat.
REQ-021 When full, m_ready high and s_valid high, the write SHALL NOT occur that cycle because s_ready is low; it SHALL be accepted in the following cycle.
REQ-022 When empty, m_valid SHALL be low and m_data/m_user are don't-care; no read SHALL occur.
REQ-023 When m_valid is high and m_ready is low, m_valid, m_data and m_user SHALL hold stable (AXIS rule).
REQ-024 Occupancy state SHALL be encoded as EMPTY (count=0), PARTIAL (0<count<DEPTH) and FULL (count=DEPTH).
REQ-025 The state transitions SHALL be:
- EMPTY to PARTIAL on a write.
- PARTIAL to FULL on a write without a read at count=DEPTH-1.
- PARTIAL to EMPTY on a read without a write at count=1.
- FULL to PARTIAL on a read.
- Every other case holds the current state.

Reset
REQ-026 While aresetn is low at a clock edge, the following SHALL be reset to 0: the pointers, count, m_valid, s_ready and the state (EMPTY).
REQ-027 s_ready SHALL rise 1 cycle after aresetn deasserts.
REQ-028 Storage contents SHALL NOT be reset.
REQ-029 A reset asserted mid-stream SHALL discard all held beats, and no stale beat SHALL appear after reset.

Configuration
REQ-030 Macro AXIS_PIXELS_FIFO_OREG_EN SHALL control the output register.
REQ-031 When AXIS_PIXELS_FIFO_OREG_EN is defined:
- m_data, m_user and m_valid SHALL come from an output register loaded from storage.
- Write-to-m_valid latency SHALL be 2 cycles when the FIFO is empty.
- The output register SHALL count toward DEPTH.
REQ-032 When AXIS_PIXELS_FIFO_OREG_EN is undefined:
- m_data and m_user SHALL be driven from storage at the read pointer.
- m_valid SHALL equal (state != EMPTY), registered.
- Write-to-m_valid latency SHALL be 1 cycle.
REQ-033 Throughput SHALL be 1 beat/cycle in both configurations under continuous valid/ready.

Structure
REQ-034 tuser_st and the ROWS/WORD_WIDTH constants SHALL come from the shared params package/header; the state enum (EMPTY/PARTIAL/FULL) SHALL be declared in that package.
REQ-035 Storage SHALL be one sub-module, fifo_ram_sdp: simple dual-port, 1 write and 1 read port, width ROWS*WORD_WIDTH+$bits(tuser_st), depth DEPTH, synchronous write.

Verification
REQ-036 The bench SHALL cover these directed scenarios in both macro settings:
- Fill/drain: with DEPTH=16 and m_ready=0, send 20 beats (data = beat index) -> s_ready falls after the 16th accept and count=16; then with m_ready=1, beats 0..15 emerge in order, followed by 16..19.
- Streaming: s_valid=m_ready=1 for 100 cycles -> 100 beats out, no bubbles after the initial latency, count constant.
- Backpressure: toggle m_ready at random with 50% probability -> m_data/m_user stable while stalled, zero loss, zero duplication.
- Full plus simultaneous: at count=16, drive s_valid=m_ready=1 -> one read in that cycle, count=15, s_ready=1 on the next edge, count returns to 16.
- Wrap: push/pop 3*DEPTH+5 beats with varied occupancy -> order preserved across pointer wrap.
- Reset mid-stream: assert aresetn=0 for 1 cycle at count=9 -> count=0 and m_valid=0 on the next cycle; the first output after reset is the first beat sent after reset.
